// File: rtl/ahb_wait_ram.sv
// ahb_wait_ram: AHB-Lite subordinate RAM with programmable wait states, byte-lane writes and two-cycle ERROR responses.
// Ports: h_clk/h_reset_n (sync active-low), address phase h_sel/h_trans/h_ready/h_addr/h_write/h_size,
//   data phase h_wstrb/h_wdata, responses h_rdata/h_readyout/h_resp.
// Optional macro AHB_WAIT_RAM_WPROT_EN: the top ProtWords words reject writes with ERROR.
module ahb_wait_ram #(
  parameter int          DataWidth  = 32,
  parameter int          NumWords   = 64,
  parameter logic [31:0] BaseAddr   = 32'h0000_0000,
  parameter int          WaitStates = 0,
  parameter int          ProtWords  = 0
) (
  input  logic                   h_clk,
  input  logic                   h_reset_n,
  input  logic                   h_sel,
  input  logic [1:0]             h_trans,
  input  logic                   h_ready,
  input  logic [31:0]            h_addr,
  input  logic                   h_write,
  input  logic [2:0]             h_size,
  input  logic [DataWidth/8-1:0] h_wstrb,
  input  logic [DataWidth-1:0]   h_wdata,
  output logic [DataWidth-1:0]   h_rdata,
  output logic                   h_readyout,
  output logic                   h_resp
);
  localparam int NB = DataWidth / 8;
  localparam int BB = $clog2(NB);
  localparam int AW = $clog2(NumWords);
  localparam logic [32:0] MemBytes = 33'(NumWords * NB);
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  state_t state;
  logic [DataWidth-1:0] mem [NumWords];
  logic [3:0] cnt;
  logic d_act, a_write;
  logic [AW-1:0] a_off, n_off;
  logic [BB-1:0] a_lo;
  logic [2:0] a_size;
  logic [31:0] rel;
  logic acc, prot, err, commit;
  logic [NB-1:0] be;
  logic [DataWidth-1:0] fwd;
  // h_readyout is high only when no data phase is stalled, so it also guards acceptance
  assign acc = h_sel & h_trans[1] & h_ready & h_readyout;
  assign rel = h_addr - BaseAddr;
  assign n_off = h_addr[BB +: AW];
`ifdef AHB_WAIT_RAM_WPROT_EN
  assign prot = h_write && (int'(n_off) >= NumWords - ProtWords);
`else
  logic unused;
  assign unused = ^{h_trans[0], 32'(ProtWords)};
  assign prot = 1'b0;
`endif
  assign err = (h_addr < BaseAddr) | ({1'b0, rel} >= MemBytes) | (h_size > 3'(BB)) |
               (|(h_addr[2:0] & ~(3'h7 << h_size))) | prot;
  // final OKAY data cycle of a write; a reset on that edge drops it
  assign commit = h_reset_n & d_act & h_readyout & a_write;
  always_comb begin
    be = '0;
    for (int b = 0; b < NB; b++)
      be[b] = h_wstrb[b] && (b >= int'(a_lo)) && (b < int'(a_lo) + (1 << a_size));
  end
  // a read accepted on the commit edge of a write to the same word sees the new bytes
  always_comb begin
    fwd = mem[n_off];
    for (int b = 0; b < NB; b++)
      if (commit && a_off == n_off && be[b]) fwd[8*b +: 8] = h_wdata[8*b +: 8];
  end
  always_ff @(posedge h_clk)
    if (commit)
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[a_off][8*b +: 8] <= h_wdata[8*b +: 8];
  always_ff @(posedge h_clk) begin
    if (!h_reset_n) begin
      state <= IDLE;
      cnt <= '0;
      d_act <= 1'b0;
      a_write <= 1'b0;
      a_off <= '0;
      a_lo <= '0;
      a_size <= '0;
      h_readyout <= 1'b1;
      h_resp <= 1'b0;
      h_rdata <= '0;
    end else if (acc) begin
      a_off <= n_off;
      a_lo <= h_addr[BB-1:0];
      a_size <= h_size;
      a_write <= h_write;
      state <= err ? ERR1 : (WaitStates == 0 ? IDLE : WAIT);
      d_act <= !err;
      cnt <= err ? 4'd0 : 4'(WaitStates);
      h_readyout <= !err && WaitStates == 0;
      h_resp <= err;
      h_rdata <= (err || h_write) ? '0 : fwd;
    end else if (state == ERR1) begin
      state <= ERR2;
      h_readyout <= 1'b1;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
      h_readyout <= cnt == 4'd1;
    end else begin
      state <= IDLE;
      d_act <= 1'b0;
      h_readyout <= 1'b1;
      h_resp <= 1'b0;
      h_rdata <= '0;
    end
  end
endmodule

// File: tb/tb_ahb_wait_ram.sv
// tb_ahb_wait_ram: random and directed AHB transfers against a byte-array reference model.
// Two instances share the bus: u0 has no wait states, u1 has three; dsel picks the active one.
module tb_ahb_wait_ram;
  logic h_clk = 0, h_reset_n = 0, sel = 0, h_ready = 1, h_write = 0;
  logic [1:0] h_trans = 0;
  logic [31:0] h_addr = 0, h_wdata = 0;
  logic [2:0] h_size = 0;
  logic [3:0] h_wstrb = 0;
  int dsel = 0;
  logic [31:0] rd0, rd1, rd;
  logic ro0, ro1, rs0, rs1, ro, rs;
  int checks = 0, errors = 0;
  logic [7:0] mm [2][256];
  bit mk [2][256];
  typedef struct {logic [31:0] a; logic w; logic [2:0] sz; logic [3:0] st; logic [31:0] d;} req_t;
  typedef struct {logic ro; logic rs; logic [31:0] rd; bit k;} exp_t;
  req_t rq[$];
  exp_t eq[$];
  always #5 h_clk = ~h_clk;
  ahb_wait_ram #(.DataWidth(32), .NumWords(64), .BaseAddr(32'h0), .WaitStates(0), .ProtWords(4)) u0 (
    .h_clk(h_clk), .h_reset_n(h_reset_n), .h_sel(sel && dsel == 0), .h_trans(h_trans), .h_ready(h_ready),
    .h_addr(h_addr), .h_write(h_write), .h_size(h_size), .h_wstrb(h_wstrb), .h_wdata(h_wdata),
    .h_rdata(rd0), .h_readyout(ro0), .h_resp(rs0));
  ahb_wait_ram #(.DataWidth(32), .NumWords(64), .BaseAddr(32'h0), .WaitStates(3), .ProtWords(4)) u1 (
    .h_clk(h_clk), .h_reset_n(h_reset_n), .h_sel(sel && dsel == 1), .h_trans(h_trans), .h_ready(h_ready),
    .h_addr(h_addr), .h_write(h_write), .h_size(h_size), .h_wstrb(h_wstrb), .h_wdata(h_wdata),
    .h_rdata(rd1), .h_readyout(ro1), .h_resp(rs1));
  assign ro = dsel == 1 ? ro1 : ro0;
  assign rs = dsel == 1 ? rs1 : rs0;
  assign rd = dsel == 1 ? rd1 : rd0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  // present an address phase and queue the expected per-cycle data-phase response
  task automatic issue(input req_t r);
    int d = dsel;
    int ws = dsel == 0 ? 0 : 3;
    int w = int'(r.a >> 2);
    int lo = int'(r.a % 4);
    bit e = r.a >= 32'h100 || r.sz > 2 || (int'(r.a) % (1 << r.sz)) != 0;
`ifdef AHB_WAIT_RAM_WPROT_EN
    e = e || (r.w && w >= 60);
`endif
    sel = 1;
    h_trans = {1'b1, 1'($urandom_range(0, 1))};
    h_ready = 1;
    h_addr = r.a;
    h_write = r.w;
    h_size = r.sz;
    if (e) begin
      eq.push_back('{1'b0, 1'b1, 32'h0, 1'b1});
      eq.push_back('{1'b1, 1'b1, 32'h0, 1'b1});
    end else begin
      logic [31:0] word;
      bit k = 1;
      for (int b = 0; b < 4; b++) begin
        word[8*b +: 8] = mm[d][w*4+b];
        k = k && mk[d][w*4+b];
      end
      for (int i = 0; i < ws; i++) eq.push_back('{1'b0, 1'b0, r.w ? 32'h0 : word, r.w || k});
      eq.push_back('{1'b1, 1'b0, r.w ? 32'h0 : word, r.w || k});
      if (r.w)
        for (int b = 0; b < 4; b++)
          if (b >= lo && b < lo + (1 << r.sz) && r.st[b]) begin
            mm[d][w*4+b] = r.d[8*b +: 8];
            mk[d][w*4+b] = 1;
          end
    end
  endtask
  task automatic run(input int gap_pct);
    int budget = 20000;
    bit started = 0;
    logic [31:0] nd = 0;
    logic [3:0] ns = 0;
    while ((rq.size() > 0 || eq.size() > 0) && budget > 0) begin
      @(posedge h_clk);
      #1;
      budget--;
      if (started) begin
        h_wdata = nd;
        h_wstrb = ns;
        started = 0;
      end
      if (eq.size() > 0) begin
        exp_t e = eq.pop_front();
        check("readyout", 32'(ro), 32'(e.ro));
        check("resp", 32'(rs), 32'(e.rs));
        if (e.k) check("rdata", rd, e.rd);
      end else begin
        check("idle_readyout", 32'(ro), 32'd1);
        check("idle_resp", 32'(rs), 32'd0);
        check("idle_rdata", rd, 32'd0);
      end
      if (eq.size() > 0) begin
        sel = 0;
        h_trans = 0;
        h_ready = 0;
      end else if (rq.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        req_t r = rq.pop_front();
        issue(r);
        nd = r.d;
        ns = r.st;
        started = 1;
      end else begin
        sel = 1'($urandom_range(0, 1));
        h_trans = {1'b0, 1'($urandom_range(0, 1))};
        h_ready = 1;
        h_addr = $urandom;
      end
    end
    if (rq.size() > 0 || eq.size() > 0) check("run_budget", 32'd0, 32'd1);
  endtask
  function automatic req_t rnd_req();
    req_t r;
    r.sz = 3'($urandom_range(0, 3));
    r.a = 32'($urandom_range(0, 71)) * 4;
    if ($urandom_range(0, 3) == 0) r.a += 32'($urandom_range(0, 3));
    r.w = 1'($urandom_range(0, 1));
    r.st = 4'($urandom);
    r.d = $urandom;
    return r;
  endfunction
  task automatic prefill();
    for (int w = 0; w < 64; w++) rq.push_back('{32'(w * 4), 1'b1, 3'd2, 4'hF, $urandom});
    run(0);
  endtask
  initial begin
    repeat (2) @(posedge h_clk);
    #1;
    check("rst_ro0", 32'(ro0), 32'd1);
    check("rst_rs0", 32'(rs0), 32'd0);
    check("rst_rd0", rd0, 32'd0);
    check("rst_ro1", 32'(ro1), 32'd1);
    check("rst_rs1", 32'(rs1), 32'd0);
    check("rst_rd1", rd1, 32'd0);
    h_reset_n = 1;
    dsel = 0;
    prefill();
    rq.push_back('{32'h10, 1'b1, 3'd2, 4'hF, 32'hDEAD_BEEF});
    rq.push_back('{32'h10, 1'b0, 3'd2, 4'h0, 32'h0});
    rq.push_back('{32'h4, 1'b1, 3'd2, 4'hF, 32'h1111_1111});
    rq.push_back('{32'h6, 1'b1, 3'd0, 4'hF, 32'h00AB_0000});
    rq.push_back('{32'h4, 1'b0, 3'd2, 4'h0, 32'h0});
    rq.push_back('{32'h6, 1'b1, 3'd0, 4'h0, 32'hFFFF_FFFF});
    rq.push_back('{32'h4, 1'b0, 3'd2, 4'h0, 32'h0});
    rq.push_back('{32'h100, 1'b0, 3'd2, 4'h0, 32'h0});
    rq.push_back('{32'h1, 1'b0, 3'd1, 4'h0, 32'h0});
    rq.push_back('{32'h8, 1'b1, 3'd3, 4'hF, 32'h5555_AAAA});
    rq.push_back('{32'h8, 1'b0, 3'd2, 4'h0, 32'h0});
    rq.push_back('{32'hF8, 1'b1, 3'd2, 4'hF, 32'h1234_5678});
    rq.push_back('{32'hF8, 1'b0, 3'd2, 4'h0, 32'h0});
    rq.push_back('{32'hEC, 1'b1, 3'd2, 4'hF, 32'h8765_4321});
    rq.push_back('{32'hEC, 1'b0, 3'd2, 4'h0, 32'h0});
    run(0);
    repeat (300) rq.push_back(rnd_req());
    run(30);
    dsel = 1;
    prefill();
    rq.push_back('{32'h0, 1'b0, 3'd2, 4'h0, 32'h0});
    rq.push_back('{32'h100, 1'b0, 3'd2, 4'h0, 32'h0});
    run(0);
    repeat (200) rq.push_back(rnd_req());
    run(30);
    @(posedge h_clk);
    #1;
    sel = 1;
    h_trans = 2'b10;
    h_ready = 1;
    h_addr = 32'h14;
    h_write = 1;
    h_size = 3'd2;
    @(posedge h_clk);
    #1;
    check("rst_wait_ro", 32'(ro), 32'd0);
    sel = 0;
    h_trans = 0;
    h_ready = 0;
    h_wdata = 32'hCAFE_F00D;
    h_wstrb = 4'hF;
    h_reset_n = 0;
    @(posedge h_clk);
    #1;
    check("rst_mid_ro", 32'(ro), 32'd1);
    check("rst_mid_rs", 32'(rs), 32'd0);
    h_reset_n = 1;
    h_ready = 1;
    rq.push_back('{32'h14, 1'b0, 3'd2, 4'h0, 32'h0});
    run(0);
    repeat (50) rq.push_back(rnd_req());
    run(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
